// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data memory / peripheral bus.
// Master 0 (CPU memory stage) has fixed priority; master 1 (debug/program
// loader) wins a slot after waiting STARVE_LIMIT contended cycles and may
// hold the bus for up to MAX_LOCK consecutive cycles through lock1.
// Grants and the memory-side mux are combinational; read data returns one
// cycle after the grant, registered per master.
//
// state | meaning
// ------+-----------------------------------------------------------
// ARB   | normal arbitration, CPU first, starvation guard for loader
// LOCK  | loader owns the bus while it keeps req1 and lock1 asserted
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_LOCK     = 16,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          rd0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          lock1,
    input  logic          rd1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall0
);

    localparam int WCW = $clog2(STARVE_LIMIT + 1);
    localparam int LCW = $clog2(MAX_LOCK + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [LCW-1:0] lock_cnt;
    logic           hold_off;

    logic           starved;
    logic [LCW-1:0] lock_cnt_next;
    logic           lock_try;
    logic           lock_force;

    assign starved = (wait_cnt == WAIT_MAX) && !hold_off;

    // Grant decision: loader keeps the bus in LOCK, otherwise CPU priority with starvation guard
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == LOCK) begin
            gnt1 = req1;
        end else if (req0 && req1) begin
            gnt1 = starved;
            gnt0 = !starved;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    // Memory-side mux; a simultaneous rd and wr is treated as a write
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_wr    = wr0;
            mem_rd    = rd0 && !wr0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_wr    = wr1;
            mem_rd    = rd1 && !wr1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign stall0 = req0 && !gnt0;

    // Lock bookkeeping: lock_cnt_next is the length of the burst including this cycle.
    // Reaching MAX_LOCK while lock1 is still asserted forces the bus back to ARB.
    always_comb begin
        lock_cnt_next = (state == LOCK) ? (lock_cnt + LCW'(1)) : LCW'(1);
        lock_try      = gnt1 && lock1 && ((state == LOCK) || !hold_off);
        lock_force    = lock_try && (lock_cnt_next >= LOCK_MAX);
    end

    // Arbitration state, starvation counter, lock counter and hold-off flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            wait_cnt <= '0;
            lock_cnt <= '0;
            hold_off <= 1'b0;
        end else begin
            if (!req1 || gnt1) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end

            if (lock_try && !lock_force) begin
                state    <= LOCK;
                lock_cnt <= lock_cnt_next;
            end else begin
                state    <= ARB;
                lock_cnt <= '0;
            end

            if (lock_force) begin
                hold_off <= 1'b1;
            end else if ((state == ARB) && (gnt0 || !req0)) begin
                hold_off <= 1'b0;
            end
        end
    end

    // Registered read return, one cycle after the granted read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 && mem_rd;
            rvalid1 <= gnt1 && mem_rd;
            if (gnt0 && mem_rd) begin
                rdata0 <= mem_rdata;
            end
            if (gnt1 && mem_rd) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int MAX_LOCK     = 16;
    localparam int AW           = 32;
    localparam int DW           = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, rd0, wr0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0, rvalid0;
    logic [DW-1:0] rdata0;
    logic          req1, lock1, rd1, wr1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1, rvalid1;
    logic [DW-1:0] rdata1;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .MAX_LOCK    (MAX_LOCK),
        .AW          (AW),
        .DW          (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .rd0      (rd0),
        .wr0      (wr0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .lock1    (lock1),
        .rd1      (rd1),
        .wr1      (wr1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall0   (stall0)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: whether a loader burst is active, how long it is,
    // how long the loader has been kept waiting, and the post-burst hold-off.
    bit            m_locked, m_hold, m_rv0, m_rv1;
    int            m_wait, m_burst;
    logic [DW-1:0] m_rd0, m_rd1;
    bit            e_g0, e_g1, e_mrd, e_mwr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    // Observed grant-cycle values, for directed checks after a tick
    logic          o_g0, o_g1, o_stall, o_mrd, o_mwr;
    logic [AW-1:0] o_addr;

    function automatic void model_reset();
        m_locked = 0; m_hold = 0; m_rv0 = 0; m_rv1 = 0;
        m_wait = 0; m_burst = 0; m_rd0 = '0; m_rd1 = '0;
    endfunction

    function automatic void model_comb();
        if (m_locked) begin
            e_g0 = 0;
            e_g1 = req1;
        end else if (req0 && req1) begin
            e_g1 = (m_wait >= STARVE_LIMIT) && !m_hold;
            e_g0 = !e_g1;
        end else begin
            e_g0 = req0;
            e_g1 = req1;
        end
        e_mrd = 0; e_mwr = 0; e_addr = '0; e_wdata = '0;
        if (e_g0) begin
            e_mwr = wr0; e_mrd = rd0 && !wr0; e_addr = addr0; e_wdata = wdata0;
        end else if (e_g1) begin
            e_mwr = wr1; e_mrd = rd1 && !wr1; e_addr = addr1; e_wdata = wdata1;
        end
    endfunction

    function automatic void model_step();
        bit was_locked;
        bit forced;
        int len;
        was_locked = m_locked;
        forced     = 0;
        m_rv0 = e_g0 && e_mrd;
        m_rv1 = e_g1 && e_mrd;
        if (m_rv0) m_rd0 = mem_rdata;
        if (m_rv1) m_rd1 = mem_rdata;
        if (req1 && !e_g1) m_wait = (m_wait + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_wait + 1;
        else m_wait = 0;
        if (e_g1 && lock1 && (was_locked || !m_hold)) begin
            len = was_locked ? m_burst + 1 : 1;
            if (len >= MAX_LOCK) begin
                forced = 1; m_locked = 0; m_burst = 0;
            end else begin
                m_locked = 1; m_burst = len;
            end
        end else begin
            m_locked = 0; m_burst = 0;
        end
        if (forced) m_hold = 1;
        else if (!was_locked && (e_g0 || !req0)) m_hold = 0;
    endfunction

    // One bus cycle: inputs are already applied after a negedge
    task automatic tick();
        #1;
        model_comb();
        o_g0 = gnt0; o_g1 = gnt1; o_stall = stall0;
        o_mrd = mem_rd; o_mwr = mem_wr; o_addr = mem_addr;
        check("gnt0", gnt0, e_g0);
        check("gnt1", gnt1, e_g1);
        check("stall0", stall0, req0 && !e_g0);
        check("mem_rd", mem_rd, e_mrd);
        check("mem_wr", mem_wr, e_mwr);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("rvalid0", rvalid0, m_rv0);
        check("rvalid1", rvalid1, m_rv1);
        check("rdata0", rdata0, m_rd0);
        check("rdata1", rdata1, m_rd1);
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        req0 = 0; rd0 = 0; wr0 = 0; req1 = 0; lock1 = 0; rd1 = 0; wr1 = 0;
        mem_rdata = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        addr0 = '0; wdata0 = '0; addr1 = '0; wdata1 = '0; mem_rdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_stall0", stall0, 1'b0);
        check("rst_rvalid0", rvalid0, 1'b0);
        check("rst_rvalid1", rvalid1, 1'b0);
        check("rst_rdata0", rdata0, '0);
        check("rst_rdata1", rdata1, '0);
        @(negedge clk);
        reset = 1'b0;

        // CPU read with one-cycle return
        req0 = 1; rd0 = 1; addr0 = 32'h10; mem_rdata = 32'hDEADBEEF;
        tick();
        check("cpu_rd_gnt0", o_g0, 1'b1);
        check("cpu_rd_addr", o_addr, 32'h10);
        check("cpu_rd_rvalid", rvalid0, 1'b1);
        check("cpu_rd_rdata", rdata0, 32'hDEADBEEF);
        idle();
        tick();
        check("cpu_rd_rvalid_drop", rvalid0, 1'b0);
        check("cpu_rd_rdata_hold", rdata0, 32'hDEADBEEF);

        // Starvation guard: loader wins the slot after STARVE_LIMIT contended cycles
        for (int i = 0; i <= STARVE_LIMIT; i++) begin
            req0 = 1; rd0 = 1; addr0 = 32'h100; req1 = 1; rd1 = 1; addr1 = 32'h200;
            mem_rdata = $urandom;
            tick();
            check("starve_gnt1", o_g1, i == STARVE_LIMIT);
            check("starve_stall0", o_stall, i == STARVE_LIMIT);
        end
        idle();
        tick();

        // Locked three-word loader write burst
        for (int i = 0; i < 3; i++) begin
            req1 = 1; wr1 = 1; lock1 = (i < 2); addr1 = 32'(i * 4); wdata1 = $urandom;
            tick();
            check("burst_gnt1", o_g1, 1'b1);
            check("burst_wr", o_mwr, 1'b1);
            check("burst_addr", o_addr, 32'(i * 4));
        end
        req0 = 1; rd0 = 0; wr0 = 1; req1 = 1; lock1 = 0; wr1 = 1;
        tick();
        check("burst_back_to_arb", o_g0, 1'b1);
        idle();
        tick();

        // Lock held against CPU contention is cut off at MAX_LOCK
        for (int i = 0; i < STARVE_LIMIT + MAX_LOCK + 4; i++) begin
            req0 = 1; rd0 = 1; wr0 = 0; addr0 = 32'h300;
            req1 = 1; lock1 = 1; rd1 = 0; wr1 = 1; addr1 = 32'(i);
            mem_rdata = $urandom;
            tick();
            check("maxlock_gnt1", o_g1, (i >= STARVE_LIMIT) && (i < STARVE_LIMIT + MAX_LOCK));
        end
        idle();
        tick();

        // rd and wr together: write wins, no read return
        req1 = 1; rd1 = 1; wr1 = 1; addr1 = 32'h44;
        tick();
        check("rdwr_mem_wr", o_mwr, 1'b1);
        check("rdwr_mem_rd", o_mrd, 1'b0);
        idle();
        tick();
        check("rdwr_no_rvalid1", rvalid1, 1'b0);

        // Reset while locked with a loader read in flight
        req1 = 1; lock1 = 1; rd1 = 1; wr1 = 0; addr1 = 32'h40;
        tick();
        check("lockrd_rvalid1", rvalid1, 1'b1);
        tick();
        req0 = 1; rd0 = 1; wr0 = 0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("midreset_rvalid0", rvalid0, 1'b0);
        check("midreset_rvalid1", rvalid1, 1'b0);
        check("midreset_rdata1", rdata1, '0);
        tick();
        reset = 1'b0;
        tick();
        check("postreset_gnt0", o_g0, 1'b1);
        check("postreset_gnt1", o_g1, 1'b0);
        idle();
        tick();

        // Random traffic; the CPU holds its command until granted
        for (int ph = 0; ph < 10; ph++) begin
            int p0, p1, pl;
            p0 = $urandom_range(10, 90);
            p1 = $urandom_range(10, 95);
            pl = $urandom_range(0, 95);
            for (int c = 0; c < 300; c++) begin
                if (!(req0 && !e_g0)) begin
                    req0   = ($urandom % 100) < p0;
                    rd0    = $urandom % 2;
                    wr0    = ($urandom % 4) == 0;
                    addr0  = $urandom;
                    wdata0 = $urandom;
                end
                req1   = ($urandom % 100) < p1;
                lock1  = ($urandom % 100) < pl;
                rd1    = $urandom % 2;
                wr1    = ($urandom % 3) == 0;
                addr1  = $urandom;
                wdata1 = $urandom;
                mem_rdata = $urandom;
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
